// File: rtl/systolic_skew_feeder.sv
// Operand feeder for a MAC array edge: skews lane i by i shift steps and sequences
// acc_rst / shift_en / acc_en for one K-vector pass. Optional stall counter: SYSTOLIC_SKEW_FEEDER_STALL_CNT_EN.
module systolic_skew_feeder #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned K_WIDTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [K_WIDTH-1:0]            k_len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic                          shift_en,
    output logic                          acc_en,
    output logic                          acc_rst,
    output logic                          busy,
`ifdef SYSTOLIC_SKEW_FEEDER_STALL_CNT_EN
    output logic [31:0]                   stall_cnt,
`endif
    output logic                          done
);

    localparam int unsigned FlushLen = 2 * (LANES - 1);
    localparam int unsigned FcW      = $clog2(FlushLen + 1);

    typedef enum logic [2:0] {StIdle, StClear, StStream, StFlush, StDone} state_e;

    state_e             state_q, state_d;
    logic [K_WIDTH-1:0] k_q, k_d;
    logic [K_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
    logic [FcW-1:0]     flush_cnt_q, flush_cnt_d;
    logic               shift_en_q, shift_en_d;
    logic               acc_en_q, acc_en_d;
    logic               acc_rst_q, acc_rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;
    logic               shift_step;

    assign in_ready   = (state_q == StStream);
    assign accept     = in_ready & in_valid;
    // Flush steps shift zeros so the tail of every lane drains out of the chains.
    assign shift_step = accept | (state_q == StFlush);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            acc_cnt_q   <= '0;
            flush_cnt_q <= '0;
            shift_en_q  <= 1'b0;
            acc_en_q    <= 1'b0;
            acc_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_cnt_q   <= acc_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            shift_en_q  <= shift_en_d;
            acc_en_q    <= acc_en_d;
            acc_rst_q   <= acc_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_cnt_d   = acc_cnt_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    k_d         = k_len;
                    acc_cnt_d   = '0;
                    flush_cnt_d = '0;
                    state_d     = StClear;
                end
            end
            StClear: begin
                state_d = (k_q != '0) ? StStream : StDone;
            end
            StStream: begin
                if (accept) begin
                    if (acc_cnt_q == k_q - K_WIDTH'(1)) begin
                        state_d = StFlush;
                    end else begin
                        acc_cnt_d = acc_cnt_q + K_WIDTH'(1);
                    end
                end
            end
            StFlush: begin
                if (flush_cnt_q == FcW'(FlushLen - 1)) begin
                    state_d = StDone;
                end else begin
                    flush_cnt_d = flush_cnt_q + FcW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered outputs trail the state by one cycle, so the done pulse lands
    // after the final presentation; busy is stretched to cover that cycle.
    always_comb begin
        shift_en_d = shift_step;
        acc_en_d   = shift_step;
        acc_rst_d  = (state_q == StClear);
        done_d     = (state_q == StDone);
        busy_d     = (state_d != StIdle) | (state_q == StDone);
    end

    assign shift_en = shift_en_q;
    assign acc_en   = acc_en_q;
    assign acc_rst  = acc_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        logic [DATA_WIDTH-1:0] chain_q [i+1];
        logic [DATA_WIDTH-1:0] chain_d [i+1];
        logic [DATA_WIDTH-1:0] lane_in;

        assign lane_in = accept ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;

        always_comb begin
            chain_d = chain_q;
            if (shift_step) begin
                chain_d[0] = lane_in;
                for (int j = 1; j <= i; j++) begin
                    chain_d[j] = chain_q[j-1];
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    chain_q[j] <= '0;
                end
            end else begin
                chain_q <= chain_d;
            end
        end

        assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = chain_q[i];
    end

`ifdef SYSTOLIC_SKEW_FEEDER_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == StIdle && start) begin
            stall_cnt_d = '0;
        end else if (state_q == StStream && !in_valid && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed self-checking bench for systolic_skew_feeder (LANES=4, DATA_WIDTH=8, K_WIDTH=8).
module tb_systolic_skew_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  k_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] out_data;
    logic        shift_en;
    logic        acc_en;
    logic        acc_rst;
    logic        busy;
    logic        done;
`ifdef SYSTOLIC_SKEW_FEEDER_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    systolic_skew_feeder #(
        .LANES      (4),
        .DATA_WIDTH (8),
        .K_WIDTH    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_data  (out_data),
        .shift_en  (shift_en),
        .acc_en    (acc_en),
        .acc_rst   (acc_rst),
        .busy      (busy),
`ifdef SYSTOLIC_SKEW_FEEDER_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    // Event log: sampled at posedge, i.e. the values held through the cycle just ending.
    logic        log_clr = 1'b0;
    int          cyc = 0;
    int          pres_n, rst_n, done_n, acc_n;
    int          pcyc [0:7];
    int          last_p, rst_c, done_c;
    logic [31:0] pres [0:7];
    logic        overlap, en_mis, rdy_seen;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (log_clr) begin
            pres_n <= 0; rst_n <= 0; done_n <= 0; acc_n <= 0;
            last_p <= 0; rst_c <= 0; done_c <= 0;
            overlap <= 1'b0; en_mis <= 1'b0; rdy_seen <= 1'b0;
        end else begin
            if (shift_en) begin
                pres_n <= pres_n + 1;
                last_p <= cyc;
                if (pres_n < 8) begin
                    pres[pres_n] <= out_data;
                    pcyc[pres_n] <= cyc;
                end
            end
            if (acc_rst) begin
                rst_n <= rst_n + 1;
                rst_c <= cyc;
                if (shift_en) overlap <= 1'b1;
            end
            if (done) begin
                done_n <= done_n + 1;
                done_c <= cyc;
            end
            if (shift_en !== acc_en) en_mis <= 1'b1;
            if (in_ready) rdy_seen <= 1'b1;
            if (in_ready && in_valid) acc_n <= acc_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lane_seq(input int l);
        logic [63:0] s = '0;
        for (int k = 0; k < 8; k++) s = {s[55:0], pres[k][l*8 +: 8]};
        return s;
    endfunction

    task automatic clear_log();
        log_clr = 1'b1;
        @(negedge clk);
        log_clr = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] k);
        start = 1'b1;
        k_len = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] v);
        logic ok = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int n = 0; n < 20 && !ok; n++) begin
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("send_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input int bound);
        logic seen = 1'b0;
        for (int n = 0; n < bound && !seen; n++) begin
            seen = done;
            if (!seen) @(negedge clk);
        end
        chk("done_seen", 64'(seen), 64'd1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic check_basic_pass(input string tag);
        chk({tag, "_pres_n"}, 64'(pres_n), 64'd8);
        chk({tag, "_lane0"}, lane_seq(0), 64'h0105_0000_0000_0000);
        chk({tag, "_lane1"}, lane_seq(1), 64'h0002_0600_0000_0000);
        chk({tag, "_lane2"}, lane_seq(2), 64'h0000_0307_0000_0000);
        chk({tag, "_lane3"}, lane_seq(3), 64'h0000_0004_0800_0000);
        chk({tag, "_rst_n"}, 64'(rst_n), 64'd1);
        chk({tag, "_done_n"}, 64'(done_n), 64'd1);
        chk({tag, "_done_after_last"}, 64'(done_c), 64'(last_p + 1));
        chk({tag, "_rst_before_pres"}, 64'(rst_c < pcyc[0]), 64'd1);
        chk({tag, "_overlap"}, 64'(overlap), 64'd0);
        chk({tag, "_en_match"}, 64'(en_mis), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; in_data = '0;
        #1;
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_shift_en", 64'(shift_en), 64'd0);
        chk("rst_acc_en", 64'(acc_en), 64'd0);
        chk("rst_acc_rst", 64'(acc_rst), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back two-vector pass
        clear_log();
        do_start(8'd2);
        chk("busy_after_start", 64'(busy), 64'd1);
        send(32'h0403_0201);
        send(32'h0807_0605);
        wait_done(50);
        check_basic_pass("b2b");
        chk("b2b_rst_then_pres", 64'(pcyc[0]), 64'(rst_c + 1));
        chk("b2b_busy_idle", 64'(busy), 64'd0);

        // Three stall cycles between the vectors
        clear_log();
        do_start(8'd2);
        send(32'h0403_0201);
        repeat (3) @(negedge clk);
        send(32'h0807_0605);
        wait_done(50);
        check_basic_pass("stall");
        chk("stall_gap", 64'(pcyc[1] - pcyc[0]), 64'd4);
`ifdef SYSTOLIC_SKEW_FEEDER_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'd3);
`endif

        // Empty pass
        clear_log();
        do_start(8'd0);
        wait_done(20);
        chk("k0_pres_n", 64'(pres_n), 64'd0);
        chk("k0_rst_n", 64'(rst_n), 64'd1);
        chk("k0_done_n", 64'(done_n), 64'd1);
        chk("k0_done_after_rst", 64'(done_c), 64'(rst_c + 1));
        chk("k0_no_ready", 64'(rdy_seen), 64'd0);

        // Restart request during STREAM is ignored
        clear_log();
        do_start(8'd2);
        send(32'h0403_0201);
        start = 1'b1;
        k_len = 8'd9;
        send(32'h0807_0605);
        start = 1'b0;
        wait_done(50);
        check_basic_pass("restart");

        // Asynchronous reset in FLUSH
        clear_log();
        do_start(8'd2);
        send(32'h0403_0201);
        send(32'h0807_0605);
        #1;
        chk("flush_busy", 64'(busy), 64'd1);
        chk("flush_data_live", 64'(out_data != '0), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_out_data", 64'(out_data), 64'd0);
        chk("arst_shift_en", 64'(shift_en), 64'd0);
        chk("arst_acc_en", 64'(acc_en), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        repeat (10) @(negedge clk);
        #1;
        chk("arst_no_done", 64'(done_n), 64'd0);
        chk("arst_no_pres", 64'(pres_n), 64'd0);
        clear_log();
        do_start(8'd2);
        send(32'h0403_0201);
        send(32'h0807_0605);
        wait_done(50);
        check_basic_pass("after_rst");

        // Maximum pass length with continuous valid
        clear_log();
        do_start(8'd255);
        in_valid = 1'b1;
        in_data  = 32'h0403_0201;
        wait_done(400);
        in_valid = 1'b0;
        chk("k255_accepts", 64'(acc_n), 64'd255);
        chk("k255_pres_n", 64'(pres_n), 64'd261);
        chk("k255_done_n", 64'(done_n), 64'd1);
`ifdef SYSTOLIC_SKEW_FEEDER_STALL_CNT_EN
        chk("k255_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
